uart_rx: RTL and testbench

// - UART receiver. 8N1 frame, LSB first, idle-high line. Samples at OVERSAMPLE x baud.
// - Sits beside the baud clock-enable generator on the RX side of the UART.
// - Realigns bit timing on every start-bit edge.
// - Hands each received byte to the fabric over a valid/ready interface.

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_os_tick.sv | 38 +++
 rtl/uart_rx.sv | 155 +++++++++++++++
 tb/tb_uart_rx.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame width and the
// oversample divisor calculation used by both the RX and TX sides.
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} uart_rx_state_t;

  localparam int UART_DATA_BITS = 8;

  // Clocks per oversample tick, truncated toward zero.
  function automatic int os_count(input int clk_mhz, input int baud, input int os);
    return (clk_mhz * 1000000) / (baud * os);
  endfunction

endpackage

// File: rtl/uart_os_tick.sv
// Free-running oversample clock enable: one-cycle tick every OS_COUNT clocks.
module uart_os_tick
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 44,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int OS_COUNT = os_count(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int CW       = (OS_COUNT > 1) ? $clog2(OS_COUNT) : 1;
  localparam logic [CW-1:0] LAST = CW'(OS_COUNT - 1);

  generate
    if (OS_COUNT < 1) begin : g_bad_divisor
      $error("uart_os_tick: clock too slow for BAUD_RATE*OVERSAMPLE");
    end
  endgenerate

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (cnt_q == LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with oversampled mid-bit sampling, break handling and a
// valid/ready output register that flags overrun when the consumer stalls.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 44,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      rx,
  output logic [UART_DATA_BITS-1:0] rx_data,
  output logic                      rx_valid,
  input  logic                      rx_ready,
  output logic                      frame_err,
  output logic                      overrun
);

  localparam int SW = $clog2(OVERSAMPLE);
  localparam int IW = $clog2(UART_DATA_BITS);
  localparam logic [SW-1:0] S_MID    = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_LAST   = SW'(OVERSAMPLE - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(UART_DATA_BITS - 1);

  generate
    if (OVERSAMPLE < 4 || (OVERSAMPLE % 2) != 0) begin : g_bad_oversample
      $error("uart_rx: OVERSAMPLE must be even and >= 4");
    end
  endgenerate

  logic tick;

  uart_os_tick #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD_RATE (BAUD_RATE),
    .OVERSAMPLE(OVERSAMPLE)
  ) u_os_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick)
  );

  // Two-flop synchroniser, reset to the idle-high line level.
  logic rx_meta_q, rxs_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rxs_q     <= rx_meta_q;
    end
  end

  uart_rx_state_t            state_q;
  logic [SW-1:0]             s_cnt_q;
  logic [IW-1:0]             idx_q;
  logic [UART_DATA_BITS-1:0] shift_q;
  logic                      deliver_q;
  logic [UART_DATA_BITS-1:0] rx_data_q;
  logic                      rx_valid_q;
  logic                      frame_err_q;
  logic                      overrun_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      s_cnt_q     <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      deliver_q   <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      deliver_q   <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;

      if (tick) begin
        case (state_q)
          IDLE: begin
            if (!rxs_q) begin
              state_q <= START;
              s_cnt_q <= '0;
            end
          end
          START: begin
            if (s_cnt_q == S_MID) begin
              if (rxs_q) begin
                state_q <= IDLE;
              end else begin
                state_q <= DATA;
                s_cnt_q <= '0;
                idx_q   <= '0;
              end
            end else begin
              s_cnt_q <= s_cnt_q + 1'b1;
            end
          end
          DATA: begin
            if (s_cnt_q == S_LAST) begin
              shift_q[idx_q] <= rxs_q;
              s_cnt_q        <= '0;
              idx_q          <= idx_q + 1'b1;
              if (idx_q == IDX_LAST) state_q <= STOP;
            end else begin
              s_cnt_q <= s_cnt_q + 1'b1;
            end
          end
          STOP: begin
            if (s_cnt_q == S_LAST) begin
              s_cnt_q <= '0;
              if (rxs_q) begin
                deliver_q <= 1'b1;
                state_q   <= IDLE;
              end else begin
                frame_err_q <= 1'b1;
                state_q     <= BREAK;
              end
            end else begin
              s_cnt_q <= s_cnt_q + 1'b1;
            end
          end
          BREAK: begin
            // A stuck-low line reports a single framing error, then waits for idle.
            if (rxs_q) state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end

      // An accept in the delivery cycle frees the register for the new byte.
      if (deliver_q) begin
        if (!rx_valid_q || rx_ready) begin
          rx_data_q  <= shift_q;
          rx_valid_q <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (rx_valid_q && rx_ready) begin
        rx_valid_q <= 1'b0;
      end
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 32 clk/bit, repeated at nominal and +/-2% line rate.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int CLK_PERIOD = 50;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;

  int  bt;
  int  pass_cnt = 0;
  int  total = 0;
  time t_start;

  int  fe_cnt = 0;
  int  ov_cnt = 0;
  int  vcyc = 0;
  int  rise_cnt = 0;
  time t_rise = 0;
  logic valid_prev = 1'b0;

  uart_rx #(
    .CLK_FREQ  (32),
    .BAUD_RATE (1000000),
    .OVERSAMPLE(16)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx       (rx),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  always #(CLK_PERIOD / 2) clk = ~clk;

  // Event monitor sampled on the inactive edge.
  always @(negedge clk) begin
    if (frame_err === 1'b1) fe_cnt <= fe_cnt + 1;
    if (overrun === 1'b1) ov_cnt <= ov_cnt + 1;
    if (rx_valid === 1'b1) vcyc <= vcyc + 1;
    if (rx_valid === 1'b1 && !valid_prev) begin
      rise_cnt <= rise_cnt + 1;
      t_rise   <= $time;
    end
    valid_prev <= (rx_valid === 1'b1);
  end

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    repeat ($urandom_range(2, 20)) @(negedge clk);
    t_start = $time;
    rx = 1'b0;
    #(bt);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      #(bt);
    end
    rx = stop_bit;
    #(bt);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    settle(3);
    total++;
    if (rx_valid !== 1'b0 || rx_data !== 8'h00 || frame_err !== 1'b0 || overrun !== 1'b0) begin
      $display("FAIL reset_outputs: got valid=%b data=%h fe=%b ov=%b, expected all 0", rx_valid, rx_data, frame_err, overrun);
    end else pass_cnt++;
    total++;
    if (dut.state_q !== IDLE) $display("FAIL reset_state: got %0d expected %0d", dut.state_q, IDLE);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    settle(4);
    $display("test_reset done");
  endtask

  task automatic test_single();
    int r0, v0, f0, o0, lat;
    rx_ready = 1'b1;
    settle(1);
    r0 = rise_cnt; v0 = vcyc; f0 = fe_cnt; o0 = ov_cnt;
    send_frame(8'hA5, 1'b1);
    settle(20);
    total++;
    if (rise_cnt - r0 !== 1) $display("FAIL t1_valid_rise: got %0d expected 1", rise_cnt - r0);
    else pass_cnt++;
    total++;
    if (vcyc - v0 !== 1) $display("FAIL t1_valid_width: got %0d expected 1", vcyc - v0);
    else pass_cnt++;
    total++;
    if (rx_data !== 8'hA5) $display("FAIL t1_data: got %h expected a5", rx_data);
    else pass_cnt++;
    total++;
    if (fe_cnt - f0 !== 0 || ov_cnt - o0 !== 0) $display("FAIL t1_flags: got fe=%0d ov=%0d expected 0 0", fe_cnt - f0, ov_cnt - o0);
    else pass_cnt++;
    lat = int'((t_rise - t_start) / CLK_PERIOD);
    total++;
    if (lat < 300 || lat > 318) $display("FAIL t1_latency: got %0d clk expected 300..318", lat);
    else pass_cnt++;
    $display("test_single bt=%0d data=%h latency=%0d", bt, rx_data, lat);
  endtask

  task automatic test_backpressure();
    int r0, o0;
    rx_ready = 1'b0;
    settle(1);
    r0 = rise_cnt; o0 = ov_cnt;
    send_frame(8'h3C, 1'b1);
    send_frame(8'hC3, 1'b1);
    settle(20);
    total++;
    if (rx_valid !== 1'b1 || rx_data !== 8'h3C) $display("FAIL t2_hold: got valid=%b data=%h expected 1 3c", rx_valid, rx_data);
    else pass_cnt++;
    total++;
    if (ov_cnt - o0 !== 1) $display("FAIL t2_overrun: got %0d expected 1", ov_cnt - o0);
    else pass_cnt++;
    total++;
    if (rise_cnt - r0 !== 1) $display("FAIL t2_rise: got %0d expected 1", rise_cnt - r0);
    else pass_cnt++;
    @(negedge clk);
    rx_ready = 1'b1;
    @(negedge clk);
    #1;
    total++;
    if (rx_valid !== 1'b0 || rx_data !== 8'h3C) $display("FAIL t2_accept: got valid=%b data=%h expected 0 3c", rx_valid, rx_data);
    else pass_cnt++;
    rx_ready = 1'b0;
    $display("test_backpressure bt=%0d data=%h", bt, rx_data);
  endtask

  task automatic test_frame_err();
    int r0, f0;
    rx_ready = 1'b1;
    settle(1);
    r0 = rise_cnt; f0 = fe_cnt;
    send_frame(8'h55, 1'b0);
    #(40 * bt);
    rx = 1'b1;
    #(2 * bt);
    settle(1);
    total++;
    if (fe_cnt - f0 !== 1) $display("FAIL t3_frame_err: got %0d expected 1", fe_cnt - f0);
    else pass_cnt++;
    total++;
    if (rise_cnt - r0 !== 0) $display("FAIL t3_no_valid: got %0d expected 0", rise_cnt - r0);
    else pass_cnt++;
    send_frame(8'h0F, 1'b1);
    settle(20);
    total++;
    if (rise_cnt - r0 !== 1 || rx_data !== 8'h0F) $display("FAIL t3_recover: got rises=%0d data=%h expected 1 0f", rise_cnt - r0, rx_data);
    else pass_cnt++;
    total++;
    if (fe_cnt - f0 !== 1) $display("FAIL t3_single_err: got %0d expected 1", fe_cnt - f0);
    else pass_cnt++;
    $display("test_frame_err bt=%0d data=%h", bt, rx_data);
  endtask

  task automatic test_glitch();
    int r0, f0;
    settle(1);
    r0 = rise_cnt; f0 = fe_cnt;
    @(negedge clk);
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    settle(64);
    total++;
    if (rise_cnt - r0 !== 0 || fe_cnt - f0 !== 0) $display("FAIL t4_glitch_flags: got rises=%0d fe=%0d expected 0 0", rise_cnt - r0, fe_cnt - f0);
    else pass_cnt++;
    total++;
    if (dut.state_q !== IDLE) $display("FAIL t4_glitch_state: got %0d expected %0d", dut.state_q, IDLE);
    else pass_cnt++;
    $display("test_glitch bt=%0d", bt);
  endtask

  task automatic test_simul();
    int o0;
    bit seen;
    rx_ready = 1'b0;
    send_frame(8'h11, 1'b1);
    settle(20);
    total++;
    if (rx_valid !== 1'b1 || rx_data !== 8'h11) $display("FAIL t5_first: got valid=%b data=%h expected 1 11", rx_valid, rx_data);
    else pass_cnt++;
    o0 = ov_cnt;
    seen = 1'b0;
    fork
      send_frame(8'h22, 1'b1);
      begin
        for (int i = 0; i < 800 && !seen; i++) begin
          @(negedge clk);
          if (dut.deliver_q === 1'b1) seen = 1'b1;
        end
        if (seen) begin
          rx_ready = 1'b1;
          @(negedge clk);
          rx_ready = 1'b0;
        end
      end
    join
    total++;
    if (!seen) $display("FAIL t5_deliver_timeout: got no delivery expected one within 800 clk");
    else pass_cnt++;
    settle(20);
    total++;
    if (rx_valid !== 1'b1 || rx_data !== 8'h22) $display("FAIL t5_second: got valid=%b data=%h expected 1 22", rx_valid, rx_data);
    else pass_cnt++;
    total++;
    if (ov_cnt - o0 !== 0) $display("FAIL t5_no_overrun: got %0d expected 0", ov_cnt - o0);
    else pass_cnt++;
    @(negedge clk);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    #1;
    total++;
    if (rx_valid !== 1'b0) $display("FAIL t5_drain: got %b expected 0", rx_valid);
    else pass_cnt++;
    $display("test_simul bt=%0d data=%h", bt, rx_data);
  endtask

  task automatic test_reset_mid();
    int r0;
    rx_ready = 1'b0;
    send_frame(8'h99, 1'b1);
    settle(20);
    fork
      send_frame(8'h5A, 1'b1);
      begin
        @(negedge rx);
        #(5 * bt + bt / 2);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        total++;
        if (rx_valid !== 1'b0 || rx_data !== 8'h00 || frame_err !== 1'b0 || overrun !== 1'b0) begin
          $display("FAIL t6_in_reset: got valid=%b data=%h fe=%b ov=%b expected 0 00 0 0", rx_valid, rx_data, frame_err, overrun);
        end else pass_cnt++;
        total++;
        if (dut.state_q !== IDLE) $display("FAIL t6_state: got %0d expected %0d", dut.state_q, IDLE);
        else pass_cnt++;
      end
    join
    #(bt);
    @(negedge clk);
    rst_n = 1'b1;
    rx_ready = 1'b1;
    settle(4);
    r0 = rise_cnt;
    send_frame(8'h81, 1'b1);
    settle(20);
    total++;
    if (rise_cnt - r0 !== 1 || rx_data !== 8'h81) $display("FAIL t6_after: got rises=%0d data=%h expected 1 81", rise_cnt - r0, rx_data);
    else pass_cnt++;
    $display("test_reset_mid bt=%0d data=%h", bt, rx_data);
  endtask

  initial begin
    int bauds[3];
    bauds[0] = 1600;
    bauds[1] = 1568;
    bauds[2] = 1632;
    rx = 1'b1;
    rx_ready = 1'b0;
    bt = bauds[0];
    test_reset();
    for (int k = 0; k < 3; k++) begin
      bt = bauds[k];
      test_single();
      test_backpressure();
      test_frame_err();
      test_glitch();
      test_simul();
      test_reset_mid();
    end
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
